// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: accepts one command, runs one NONSEQ transfer,
// waits out slave wait states (with a timeout), and returns a lane-aligned response.
module ahb_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic [1:0]  htrans,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [3:0]        addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tout_q, tout_d;

    logic [31:0]       size_mask;
    logic [4:0]        lane_sh;
    logic              cmd_legal;

    // Lane mask and byte-lane shift derived from the latched command.
    always_comb begin
        size_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        lane_sh = {addr_q[1:0], 3'b000};
    end

    // Alignment/size legality of the incoming command.
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_size)
            2'd0:    cmd_legal = 1'b1;
            2'd1:    cmd_legal = ~cmd_addr[0];
            2'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // Next-state: command latch, transfer sequencing, wait counter and response capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tout_d  = tout_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    wdata_d = cmd_wdata;
                    wait_d  = '0;
                    tout_d  = 1'b0;
                    if (cmd_legal) begin
                        state_d = StAddr;
                    end else begin
                        // Rejected locally: no bus activity at all.
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
                end
            end
            StAddr, StData: begin
                if (hready) begin
                    wait_d = '0;
                    if (state_q == StAddr) begin
                        state_d = StData;
                    end else begin
                        state_d = StResp;
                        err_d   = hresp;
                        tout_d  = 1'b0;
                        if (!write_q) begin
                            rdata_d = (hrdata >> lane_sh) & size_mask;
                        end
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    // Outputs decode from registered state and latched command only.
    always_comb begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_error   = 1'b0;
        rsp_timeout = 1'b0;
        hsel        = 1'b0;
        haddr       = '0;
        htrans      = 2'b00;
        hsize       = '0;
        hwrite      = 1'b0;
        hwdata      = '0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StAddr: begin
                hsel   = 1'b1;
                htrans = 2'b10;
                haddr  = addr_q;
                hsize  = size_q;
                hwrite = write_q;
            end
            StData: begin
                if (write_q) begin
                    hwdata = (wdata_q & size_mask) << lane_sh;
                end
            end
            StResp: begin
                rsp_valid   = 1'b1;
                rsp_error   = err_q;
                rsp_timeout = tout_q;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a cycle-indexed slave drives hready/hresp/hrdata,
// expected responses go through a scoreboard queue and are checked when rsp_valid appears.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        hsel;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tout;
        int          lat;
    } rsp_t;

    rsp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    ahb_lite_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_size    (cmd_size),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .hsel        (hsel),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsize       (hsize),
        .hwrite      (hwrite),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One command; aw/dw = hready-low cycles in address/data phase; herr drives hresp in data.
    task automatic xfer(input logic w, input logic [3:0] a, input logic [1:0] s,
                        input logic [31:0] wd, input logic [31:0] hrd, input int aw,
                        input int dw, input logic herr, input logic [31:0] exp_hwdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_tout, input int exp_lat);
        rsp_t e;
        rsp_t got;
        int   lat;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = wd;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.tout  = exp_tout;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            if (lat <= aw + 1) begin
                chk("htrans_addr", {30'd0, htrans}, 32'd2);
                chk("hsel_addr", {31'd0, hsel}, 32'd1);
                chk("haddr", {28'd0, haddr}, {28'd0, a});
                chk("hsize", {30'd0, hsize}, {30'd0, s});
                chk("hwrite", {31'd0, hwrite}, {31'd0, w});
                chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
                hready = (lat == aw + 1);
                hresp  = 1'b0;
            end else begin
                chk("htrans_data", {30'd0, htrans}, 32'd0);
                chk("hsel_data", {31'd0, hsel}, 32'd0);
                if (w) chk("hwdata", hwdata, exp_hwdata);
                hready = (lat - aw - 1 == dw + 1);
                hresp  = herr;
                hrdata = hready ? hrd : 32'hBAD0_BAD0;
            end
            @(negedge clk);
            lat++;
        end
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        got = sb.pop_front();
        if (rsp_valid) begin
            chk("rsp_latency", lat, got.lat);
            chk("rsp_rdata", rsp_rdata, got.rdata);
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, got.err});
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, got.tout});
        end
        chk("htrans_resp", {30'd0, htrans}, 32'd0);
        chk("hsel_resp", {31'd0, hsel}, 32'd0);
        chk("hwdata_resp", hwdata, 32'd0);
        chk("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        n_rst     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_hsel", {31'd0, hsel}, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_haddr", {28'd0, haddr}, 32'd0);
        chk("rst_hsize", {30'd0, hsize}, 32'd0);
        chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        n_rst = 1'b1;

        // w  addr   size  wdata         hrdata        aw   dw  herr  hwdata        rdata         err   to    lat
        xfer(1, 4'h0, 2'd2, 32'hDEADBEEF, 32'h0,       0,   0,  0, 32'hDEADBEEF, 32'h0,        0,    0,    3);
        xfer(1, 4'h2, 2'd0, 32'h000000A5, 32'h0,       0,   0,  0, 32'h00A50000, 32'h0,        0,    0,    3);
        xfer(0, 4'h2, 2'd1, 32'h0,        32'h12340000, 0,  2,  0, 32'h0,        32'h00001234, 0,    0,    5);
        xfer(1, 4'h1, 2'd2, 32'h11111111, 32'h0,       0,   0,  0, 32'h0,        32'h00001234, 1,    0,    1);
        xfer(0, 4'h0, 2'd3, 32'h0,        32'h0,       0,   0,  0, 32'h0,        32'h00001234, 1,    0,    1);
        xfer(0, 4'h3, 2'd1, 32'h0,        32'h0,       0,   0,  0, 32'h0,        32'h00001234, 1,    0,    1);
        xfer(1, 4'hE, 2'd1, 32'h1234CAFE, 32'h0,       0,   1,  1, 32'hCAFE0000, 32'h00001234, 1,    0,    4);
        xfer(0, 4'h4, 2'd2, 32'h0,        32'h89ABCDEF, 0,  0,  0, 32'h0,        32'h89ABCDEF, 0,    0,    3);
        xfer(0, 4'h7, 2'd0, 32'h0,        32'h5A000000, 1,  0,  0, 32'h0,        32'h0000005A, 0,    0,    4);
        xfer(1, 4'h5, 2'd0, 32'hFFFFFF3C, 32'h0,       0,   0,  0, 32'h00003C00, 32'h0000005A, 0,    0,    3);
        xfer(0, 4'h8, 2'd2, 32'h0,        32'h0,       100, 0,  0, 32'h0,        32'h0000005A, 1,    1,    17);

        // Reset asserted while a new command sits in its address phase.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'hC;
        cmd_size  = 2'd2;
        cmd_wdata = 32'h0000_0001;
        hready    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rst_addr_phase", {30'd0, htrans}, 32'd2);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_htrans", {30'd0, htrans}, 32'd0);
        chk("mid_rst_hsel", {31'd0, hsel}, 32'd0);
        chk("mid_rst_haddr", {28'd0, haddr}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        n_rst  = 1'b1;
        hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("post_rst_htrans", {30'd0, htrans}, 32'd0);
        end
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
